// File: rtl/mem_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_lsu                                                        |
// | Purpose  : Load/store initiator for the OTTER multicycle core. Accepts    |
// |            one byte-addressed CPU access at a time, checks alignment,     |
// |            drives a single-port byte-enable BRAM (1-cycle registered      |
// |            read) and returns sign/zero-extended load data together with   |
// |            a one-cycle response pulse.                                    |
// | Ports    : clk, rst_n (synchronous, active low)                          |
// |            req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/     |
// |            req_wdata    : CPU request side                                |
// |            resp_valid/resp_rdata/resp_err : CPU response side             |
// |            bram_rd/bram_we/bram_addr/bram_data/bram_out : BRAM side       |
// | Options  : define MEM_RANGE_CHECK_EN to flag requests whose address bits  |
// |            above the BRAM word range are nonzero as errors; otherwise     |
// |            those bits are dropped and the address wraps.                 |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mem_lsu #(
    parameter int RAM_ADDR_WIDTH = 13,
    parameter int RAM_BUS_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic                      bram_rd,
    output logic [3:0]                bram_we,
    output logic [RAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [RAM_BUS_WIDTH-1:0]  bram_data,
    input  logic [RAM_BUS_WIDTH-1:0]  bram_out
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;

    logic                      r_we;
    logic [1:0]                r_size;
    logic                      r_uns;
    logic [1:0]                r_off;
    logic                      r_err;
    logic [RAM_ADDR_WIDTH-1:0] r_waddr;
    logic [3:0]                r_mask;
    logic [31:0]               r_bdata;
    logic [31:0]               r_rdata;

    logic                      w_accept;
    logic [1:0]                w_off;
    logic                      w_misalign;
    logic                      w_range_err;
    logic                      w_req_err;
    logic [3:0]                w_mask;
    logic [31:0]               w_wdata_rep;
    logic [7:0]                w_ld_byte;
    logic [15:0]               w_ld_half;
    logic [31:0]               w_load_ext;

    assign w_accept = req_valid && (r_state == c_IDLE);
    assign w_off    = req_addr[1:0];

    assign w_misalign = (req_size == 2'b11)
                     || ((req_size == c_SZ_HALF) && w_off[0])
                     || ((req_size == c_SZ_WORD) && (w_off != 2'b00));

`ifdef MEM_RANGE_CHECK_EN
    assign w_range_err = |req_addr[31:RAM_ADDR_WIDTH+2];
`else
    // Upper address bits are intentionally dropped so the address wraps.
    logic [31-(RAM_ADDR_WIDTH+2):0] w_unused_addr_hi;
    assign w_unused_addr_hi = req_addr[31:RAM_ADDR_WIDTH+2];
    assign w_range_err      = 1'b0;
`endif

    assign w_req_err = w_misalign || w_range_err;

    // Byte-lane mask and lane-replicated write data, computed at accept time
    // so the ACCESS cycle only has to gate registered values onto the bus.
    always_comb begin
        w_mask      = 4'b0000;
        w_wdata_rep = req_wdata;
        case (req_size)
            c_SZ_BYTE: begin
                w_mask      = 4'b0001 << w_off;
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_mask      = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                w_mask      = 4'b1111;
                w_wdata_rep = req_wdata;
            end
        endcase
    end

    // Lane extraction from the BRAM word; halves are always 16-bit aligned
    // here because misaligned halves never reach the BRAM.
    assign w_ld_byte = bram_out[{r_off, 3'b000} +: 8];
    assign w_ld_half = bram_out[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = bram_out;
        case (r_size)
            c_SZ_BYTE: w_load_ext = r_uns ? {24'd0, w_ld_byte}
                                          : {{24{w_ld_byte[7]}}, w_ld_byte};
            c_SZ_HALF: w_load_ext = r_uns ? {16'd0, w_ld_half}
                                          : {{16{w_ld_half[15]}}, w_ld_half};
            default:   w_load_ext = bram_out;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_req_err ? c_RESP : c_ACCESS;
                end
            end
            c_ACCESS: w_next_state = r_we ? c_RESP : c_WAIT;
            c_WAIT:   w_next_state = c_RESP;
            c_RESP:   w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // Request capture and load-data register. The response data is cleared
    // on every accept so stores and errors return zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_off   <= 2'b00;
            r_err   <= 1'b0;
            r_waddr <= '0;
            r_mask  <= 4'b0000;
            r_bdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_off   <= w_off;
                r_err   <= w_req_err;
                r_waddr <= req_addr[RAM_ADDR_WIDTH+1:2];
                r_mask  <= w_mask;
                r_bdata <= w_wdata_rep;
                r_rdata <= 32'd0;
            end else if (r_state == c_WAIT) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    // Strobes are decoded from the state register only, so they are
    // mutually exclusive and confined to ACCESS by construction.
    assign req_ready  = (r_state == c_IDLE);
    assign bram_rd    = (r_state == c_ACCESS) && !r_we;
    assign bram_we    = ((r_state == c_ACCESS) && r_we) ? r_mask : 4'b0000;
    assign bram_addr  = r_waddr;
    assign bram_data  = r_bdata;
    assign resp_valid = (r_state == c_RESP);
    assign resp_err   = (r_state == c_RESP) && r_err;
    assign resp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_lsu                                                     |
// | Purpose  : Scoreboard testbench for mem_lsu with a behavioural BRAM.      |
// |            Directed requests push expected BRAM strobes and responses     |
// |            into queues; a monitor compares them as the DUT emits them.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_lsu;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          bram_rd;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_data;
    logic [31:0]   bram_out;

    mem_lsu #(.RAM_ADDR_WIDTH(AW), .RAM_BUS_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .bram_rd      (bram_rd),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_data    (bram_data),
        .bram_out     (bram_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM: byte-enable write, registered read.
    logic [31:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
        bram_out = 32'd0;
    end
    always @(posedge clk) begin
        if (bram_we[0]) mem[bram_addr][7:0]   <= bram_data[7:0];
        if (bram_we[1]) mem[bram_addr][15:8]  <= bram_data[15:8];
        if (bram_we[2]) mem[bram_addr][23:16] <= bram_data[23:16];
        if (bram_we[3]) mem[bram_addr][31:24] <= bram_data[31:24];
        if (bram_rd)    bram_out <= mem[bram_addr];
    end

    typedef struct {
        logic          rd;
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          chk_data;
        int            t0;
    } strobe_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } resp_t;

    strobe_t sq[$];
    resp_t   rq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every BRAM strobe and every response against the queues.
    strobe_t ms;
    resp_t   mr;
    always @(negedge clk) begin
        if (bram_rd || (|bram_we)) begin
            if (bram_rd && (|bram_we)) begin
                check32("strobe_exclusive", {27'd0, bram_rd, bram_we}, {28'd0, bram_we});
            end
            if (sq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: rd=%0b we=%b addr=0x%0h, expected no strobe (cycle %0d)",
                         bram_rd, bram_we, bram_addr, cyc);
            end else begin
                ms = sq.pop_front();
                check32("strobe_rd",   {31'd0, bram_rd}, {31'd0, ms.rd});
                check32("strobe_we",   {28'd0, bram_we}, {28'd0, ms.we});
                check32("strobe_addr", {19'd0, bram_addr}, {19'd0, ms.addr});
                if (ms.chk_data) check32("strobe_data", bram_data, ms.data);
                check32("strobe_time", cyc + 1 - ms.t0, 32'd1);
            end
        end
        if (resp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: err=%0b rdata=0x%08h, expected no response (cycle %0d)",
                         resp_err, resp_rdata, cyc);
            end else begin
                mr = rq.pop_front();
                check32("resp_rdata",   resp_rdata, mr.rdata);
                check32("resp_err",     {31'd0, resp_err}, {31'd0, mr.err});
                check32("resp_latency", cyc + 1 - mr.t0, mr.lat);
            end
        end
    end

    // Issue one request; expectations are pushed once the accept edge is known.
    task automatic issue(
        input logic          we,
        input logic [1:0]    size,
        input logic          uns,
        input logic [31:0]   addr,
        input logic [31:0]   wdata,
        input logic          has_strobe,
        input logic [3:0]    s_we,
        input logic [AW-1:0] s_addr,
        input logic [31:0]   s_data,
        input logic          has_resp,
        input logic [31:0]   e_rdata,
        input logic          e_err,
        input int            e_lat
    );
        int      waited;
        strobe_t s;
        resp_t   r;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout: ready=%0b, expected 1", req_ready);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = 2'b11;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = 32'h5555_5555;
        if (has_strobe) begin
            s.rd       = ~we;
            s.we       = s_we;
            s.addr     = s_addr;
            s.data     = s_data;
            s.chk_data = we;
            s.t0       = cyc;
            sq.push_back(s);
        end
        if (has_resp) begin
            r.rdata = e_rdata;
            r.err   = e_err;
            r.lat   = e_lat;
            r.t0    = cyc;
            rq.push_back(r);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
        check32({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check32({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
        check32({tag, "_resp_rdata"}, resp_rdata,          32'd0);
        check32({tag, "_bram_rd"},    {31'd0, bram_rd},    32'd0);
        check32({tag, "_bram_we"},    {28'd0, bram_we},    32'd0);
        check32({tag, "_bram_addr"},  {19'd0, bram_addr},  32'd0);
        check32({tag, "_bram_data"},  bram_data,           32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        //     we    size   uns  addr          wdata         strb  we       baddr   bdata         resp  rdata         err  lat
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4'b1111, 13'd4,  32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 4'b0000, 13'd4,  32'h0,         1'b1, 32'hFFFF_FFDE, 1'b0, 3);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         1'b1, 4'b0000, 13'd4,  32'h0,         1'b1, 32'h0000_00DE, 1'b0, 3);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_1234, 1'b1, 4'b1100, 13'd8,  32'h1234_1234, 1'b1, 32'h0000_0000, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,         1'b1, 4'b0000, 13'd8,  32'h0,         1'b1, 32'h0000_1234, 1'b0, 3);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 4'b0000, 13'd4,  32'h0,         1'b1, 32'hFFFF_BEEF, 1'b0, 3);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'h0000_00A5, 1'b1, 4'b0010, 13'd12, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,         1'b1, 4'b0000, 13'd12, 32'h0,         1'b1, 32'h0000_A500, 1'b0, 3);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 4'b0000, 13'd4,  32'h0,         1'b1, 32'hFFFF_FFAD, 1'b0, 3);
        // Errors: misaligned word, illegal size, misaligned half
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         1'b0, 4'b0000, 13'd0,  32'h0,         1'b1, 32'h0000_0000, 1'b1, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 4'b0000, 13'd0,  32'h0,         1'b1, 32'h0000_0000, 1'b1, 1);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_BEEF, 1'b0, 4'b0000, 13'd0,  32'h0,         1'b1, 32'h0000_0000, 1'b1, 1);
        // Upper address bits: wrap to word 0 or range error
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h8000_0001, 1'b1, 4'b1111, 13'd0,  32'h8000_0001, 1'b1, 32'h0000_0000, 1'b0, 2);
`ifdef MEM_RANGE_CHECK_EN
        issue(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0,         1'b0, 4'b0000, 13'd0,  32'h0,         1'b1, 32'h0000_0000, 1'b1, 1);
`else
        issue(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0,         1'b1, 4'b0000, 13'd0,  32'h0,         1'b1, 32'h8000_0001, 1'b0, 3);
`endif

        // Reset while the load sits in WAIT: strobe seen, no response.
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 4'b0000, 13'd4,  32'h0,         1'b0, 32'h0,         1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 4'b0000, 13'd4,  32'h0,         1'b1, 32'hFFFF_FFDE, 1'b0, 3);

        w = 0;
        while ((sq.size() != 0 || rq.size() != 0) && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        check32("queues_drained", sq.size() + rq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator for the OTTER multicycle core; the requesting end of the single-port byte-enable block RAM interface.
- Accepts one CPU byte-addressed access at a time and checks alignment.
- Drives BRAM rd/we/addr/data, absorbs the BRAM's one-cycle registered read latency, and returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
- RAM_ADDR_WIDTH, 13, word-address width of the attached BRAM (8K x 32).
- RAM_BUS_WIDTH, 32, BRAM data width; only 32 is supported.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  CPU access request
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores and errors
- resp_err  output  1  access aborted, valid with resp_valid
- bram_rd  output  1  BRAM read strobe
- bram_we  output  4  BRAM byte write enables
- bram_addr  output  RAM_ADDR_WIDTH  BRAM word address
- bram_data  output  32  BRAM write data
- bram_out  input  32  BRAM read data, valid the cycle after bram_rd

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; bram_rd=0; bram_we=0; bram_addr=0; bram_data=0.
- Reset applied mid-operation aborts the access: no response is produced and strobes drop on the next edge.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE, on accept:
  - Latch all request fields and compute offset o = req_addr[1:0].
  - Error if size=11, or half with o[0]=1, or word with o!=0. On error go to RESP with err=1 and no BRAM strobe.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - bram_addr = addr[RAM_ADDR_WIDTH+1:2].
  - Load: bram_rd=1, bram_we=0, next state WAIT.
  - Store: bram_rd=0, bram_we=mask, next state RESP.
  - Masks: byte = 1<<o; half = 0011 (o=0) or 1100 (o=2); word = 1111.
  - bram_data: byte = 4 copies of wdata[7:0]; half = 2 copies of wdata[15:0]; word = wdata.
- WAIT:
  - bram_rd=0; bram_addr held.
  - Extract byte bram_out[8*o+:8], or half bram_out[8*o+:16], or the full word; extend per req_unsigned; register into the response data. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Strobes: bram_rd and bram_we are never both nonzero, and both are zero outside ACCESS.
- Latency from the accept edge T0: load resp_valid at T3, store at T2, error at T1. Throughput is one access per 4 cycles (load), 3 (store), 2 (error).
- Address bits above RAM_ADDR_WIDTH+1 are ignored (address wraps) unless the optional feature is enabled.
- req_* inputs are ignored while req_ready=0.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined: in IDLE, a request with any nonzero req_addr[31:RAM_ADDR_WIDTH+2] is flagged as an error: RESP with resp_err=1 at T1, no BRAM strobe.
- Undefined: no range check; upper address bits are silently dropped.

Test Plan:
- Reset then store word: addr 0x10, wdata 0xDEADBEEF -> T1 bram_we=1111, bram_addr=4, bram_data=0xDEADBEEF; T2 resp_valid=1, err=0.
- Load byte signed: mem[4]=0xDEADBEEF, addr 0x13 -> T1 bram_rd=1, bram_addr=4; T3 resp_rdata=0xFFFFFFDE. Same with req_unsigned=1 -> 0x000000DE.
- Store half at 0x22, wdata 0x00001234 -> bram_we=1100, bram_data=0x12341234; load half unsigned at 0x22 -> 0x00001234.
- Misaligned word load at 0x06, then size=11 at 0x00 -> each gives resp_valid with err=1 at T1, bram_rd and bram_we stay 0 throughout.
- Reset asserted in WAIT of a load at 0x13 -> no resp_valid; next cycle all outputs at reset values; a following load completes normally.
- MEM_RANGE_CHECK_EN defined, load addr 0x00008000 -> err=1 at T1, no strobe. Undefined -> bram_addr=0, normal load at T3.
